// File: rtl/hesap_cekirdek.sv
`default_nettype none
// ============================================================================
// hesap_cekirdek : multi-cycle integer calculator core (add/sub/mul/div/isqrt)
// Rev 1.0 - initial release
// ============================================================================
module hesap_cekirdek #(
  parameter int GENISLIK = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    basla,
  input  logic [GENISLIK-1:0]     sayi1,
  input  logic [GENISLIK-1:0]     sayi2,
  input  logic [2:0]              tur,
  output logic [2*GENISLIK-1:0]   sonuc,
  output logic                    hazir,
  output logic                    gecerli,
  output logic                    tasma,
  output logic                    tamam
);

  localparam int W  = GENISLIK;
  localparam int SW = $clog2(GENISLIK + 1);

  localparam logic [2:0] OP_TOPLA = 3'b000;
  localparam logic [2:0] OP_CIKAR = 3'b001;
  localparam logic [2:0] OP_CARP  = 3'b010;
  localparam logic [2:0] OP_BOL   = 3'b011;
  localparam logic [2:0] OP_KOK   = 3'b100;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    HESAP = 2'd1,
    BITTI = 2'd2
  } durum_t;

  durum_t             durum_q;
  logic [2*W-1:0]     sonuc_q;
  logic               hazir_q;
  logic               gecerli_q;
  logic               tasma_q;
  logic               tamam_q;
  logic [2:0]         tur_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       hi_q;
  logic [W-1:0]       lo_q;
  logic [W/2-1:0]     kok_q;
  logic [SW-1:0]      sayac_q;

  logic [W-1:0]       hi_d;
  logic [W-1:0]       lo_d;
  logic [W/2-1:0]     kok_d;
  logic [W:0]         carp_top;
  logic [W:0]         bol_kay;
  logic [W+1:0]       kok_kay;
  logic [W+1:0]       kok_den;
  logic [W:0]         topla;
  logic [W-1:0]       cikar;

  // hi_q/lo_q are shared: partial product/multiplier, remainder/dividend,
  // or remainder/radicand depending on the captured operation.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    kok_d    = kok_q;
    carp_top = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    bol_kay  = {hi_q, lo_q[W-1]};
    kok_kay  = {hi_q, lo_q[W-1:W-2]};
    kok_den  = {{(W/2){1'b0}}, kok_q, 2'b01};
    topla    = {1'b0, lo_q} + {1'b0, b_q};
    cikar    = lo_q - b_q;
    case (tur_q)
      OP_CARP: begin
        hi_d = carp_top[W:1];
        lo_d = {carp_top[0], lo_q[W-1:1]};
      end
      OP_BOL: begin
        if (bol_kay >= {1'b0, b_q}) begin
          hi_d = bol_kay[W-1:0] - b_q;
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = bol_kay[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end
      OP_KOK: begin
        lo_d = {lo_q[W-3:0], 2'b00};
        if (kok_kay >= kok_den) begin
          hi_d  = kok_kay[W-1:0] - kok_den[W-1:0];
          kok_d = {kok_q[W/2-2:0], 1'b1};
        end else begin
          hi_d  = kok_kay[W-1:0];
          kok_d = {kok_q[W/2-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q   <= BOS;
      sonuc_q   <= '0;
      hazir_q   <= 1'b1;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
      tamam_q   <= 1'b0;
      tur_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      kok_q     <= '0;
      sayac_q   <= '0;
    end else begin
      case (durum_q)
        BOS: begin
          tamam_q <= 1'b0;
          if (basla) begin
            tur_q   <= tur;
            b_q     <= sayi2;
            lo_q    <= sayi1;
            hi_q    <= '0;
            kok_q   <= '0;
            hazir_q <= 1'b0;
            durum_q <= BITTI;
            if (tur == OP_CARP || (tur == OP_BOL && sayi2 != '0)) begin
              sayac_q <= SW'(W);
              durum_q <= HESAP;
            end else if (tur == OP_KOK) begin
              sayac_q <= SW'(W/2);
              durum_q <= HESAP;
            end
          end
        end
        HESAP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          kok_q   <= kok_d;
          sayac_q <= sayac_q - SW'(1);
          if (sayac_q == SW'(1)) durum_q <= BITTI;
        end
        BITTI: begin
          tamam_q   <= 1'b1;
          hazir_q   <= 1'b1;
          durum_q   <= BOS;
          gecerli_q <= 1'b1;
          tasma_q   <= 1'b0;
          case (tur_q)
            OP_TOPLA: begin
              sonuc_q <= {{(W-1){1'b0}}, topla};
              tasma_q <= topla[W];
            end
            OP_CIKAR: begin
              sonuc_q <= {{W{1'b0}}, cikar};
              tasma_q <= (b_q > lo_q);
            end
            OP_CARP: begin
              sonuc_q <= {hi_q, lo_q};
              tasma_q <= (hi_q != '0);
            end
            OP_BOL: begin
              if (b_q == '0) begin
                sonuc_q   <= '0;
                tasma_q   <= 1'b1;
                gecerli_q <= 1'b0;
              end else begin
                sonuc_q <= {hi_q, lo_q};
              end
            end
            OP_KOK: sonuc_q <= {{(3*W/2){1'b0}}, kok_q};
            default: begin
              sonuc_q   <= '0;
              gecerli_q <= 1'b0;
            end
          endcase
        end
        default: durum_q <= BOS;
      endcase
    end
  end

  assign sonuc   = sonuc_q;
  assign hazir   = hazir_q;
  assign gecerli = gecerli_q;
  assign tasma   = tasma_q;
  assign tamam   = tamam_q;

endmodule
`default_nettype wire

// File: tb/tb_hesap_cekirdek.sv
`default_nettype none
// ============================================================================
// tb_hesap_cekirdek : directed self-checking bench for hesap_cekirdek
// Rev 1.0 - initial release
// ============================================================================
module tb_hesap_cekirdek;

  logic        clk;
  logic        rst;
  logic        basla;
  logic [31:0] sayi1;
  logic [31:0] sayi2;
  logic [2:0]  tur;
  logic [63:0] sonuc;
  logic        hazir, gecerli, tasma, tamam;

  logic        basla8;
  logic [7:0]  sayi1_8, sayi2_8;
  logic [2:0]  tur8;
  logic [15:0] sonuc8;
  logic        hazir8, gecerli8, tasma8, tamam8;

  int n_kontrol = 0;
  int n_hata    = 0;

  hesap_cekirdek #(.GENISLIK(32)) u_dut (
    .clk(clk), .rst(rst), .basla(basla), .sayi1(sayi1), .sayi2(sayi2),
    .tur(tur), .sonuc(sonuc), .hazir(hazir), .gecerli(gecerli),
    .tasma(tasma), .tamam(tamam)
  );

  hesap_cekirdek #(.GENISLIK(8)) u_dut8 (
    .clk(clk), .rst(rst), .basla(basla8), .sayi1(sayi1_8), .sayi2(sayi2_8),
    .tur(tur8), .sonuc(sonuc8), .hazir(hazir8), .gecerli(gecerli8),
    .tasma(tasma8), .tamam(tamam8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  // Issue one request, scramble inputs after capture, poke a stray basla
  // mid-flight, and check latency, busy window, result and single pulse.
  task automatic calistir(input string etiket, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e_sonuc, input logic e_tasma,
                          input logic e_gecerli, input int e_gecikme);
    int n;
    int mesgul;
    @(negedge clk);
    tur = t; sayi1 = a; sayi2 = b; basla = 1'b1;
    @(posedge clk); #1;
    basla = 1'b0; sayi1 = $urandom; sayi2 = $urandom; tur = 3'($urandom_range(0, 7));
    n = 0; mesgul = 0;
    while (!tamam && n < 200) begin
      if (!hazir) mesgul++;
      if (n == 3) begin
        basla = 1'b1; tur = 3'b000; sayi1 = 32'h1; sayi2 = 32'h2;
      end
      if (n == 6) basla = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    basla = 1'b0;
    kontrol({etiket, "_gecikme"}, 64'(n), 64'(e_gecikme));
    kontrol({etiket, "_mesgul"}, 64'(mesgul), 64'(e_gecikme));
    kontrol({etiket, "_sonuc"}, sonuc, e_sonuc);
    kontrol({etiket, "_tasma"}, 64'(tasma), 64'(e_tasma));
    kontrol({etiket, "_gecerli"}, 64'(gecerli), 64'(e_gecerli));
    kontrol({etiket, "_hazir"}, 64'(hazir), 64'd1);
    @(posedge clk); #1;
    kontrol({etiket, "_tek_darbe"}, 64'(tamam), 64'd0);
  endtask

  initial begin
    int darbe;
    rst = 1'b1; basla = 1'b0; sayi1 = '0; sayi2 = '0; tur = '0;
    basla8 = 1'b0; sayi1_8 = '0; sayi2_8 = '0; tur8 = '0;
    repeat (3) @(posedge clk);
    #1;
    kontrol("rst_sonuc", sonuc, 64'h0);
    kontrol("rst_hazir", 64'(hazir), 64'd1);
    kontrol("rst_gecerli", 64'(gecerli), 64'd0);
    kontrol("rst_tasma", 64'(tasma), 64'd0);
    kontrol("rst_tamam", 64'(tamam), 64'd0);
    @(negedge clk); rst = 1'b0;

    calistir("topla_tasma", 3'b000, 32'hFFFF_FFFF, 32'h1, 64'h0000_0001_0000_0000, 1'b1, 1'b1, 1);
    calistir("cikar_borc",  3'b001, 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE, 1'b1, 1'b1, 1);
    calistir("cikar",       3'b001, 32'd5, 32'd3, 64'd2, 1'b0, 1'b1, 1);
    calistir("carp_tam",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1, 33);
    calistir("carp_kucuk",  3'b010, 32'h1234, 32'h10, 64'h12340, 1'b0, 1'b1, 33);
    calistir("bol",         3'b011, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 1'b1, 33);
    calistir("bol_sifir",   3'b011, 32'd5, 32'd0, 64'h0, 1'b1, 1'b0, 1);
    calistir("kok",         3'b100, 32'd1000000, 32'hDEAD_BEEF, 64'd1000, 1'b0, 1'b1, 17);
    calistir("kok_max",     3'b100, 32'hFFFF_FFFF, 32'h0, 64'd65535, 1'b0, 1'b1, 17);

    // Reset ten cycles into a multiply: abort silently, clear outputs.
    @(negedge clk);
    tur = 3'b010; sayi1 = 32'h55; sayi2 = 32'h77; basla = 1'b1;
    @(posedge clk); #1; basla = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    kontrol("rst_ucus_hazir", 64'(hazir), 64'd1);
    kontrol("rst_ucus_sonuc", sonuc, 64'h0);
    kontrol("rst_ucus_gecerli", 64'(gecerli), 64'd0);
    kontrol("rst_ucus_tamam", 64'(tamam), 64'd0);
    @(negedge clk); rst = 1'b0;
    darbe = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tamam) darbe++;
    end
    kontrol("rst_ucus_tamam_yok", 64'(darbe), 64'd0);

    calistir("gecersiz", 3'b111, 32'd9, 32'd4, 64'h0, 1'b0, 1'b0, 1);

    // Narrow instance: add overflow at W=8.
    @(negedge clk);
    tur8 = 3'b000; sayi1_8 = 8'hFF; sayi2_8 = 8'h01; basla8 = 1'b1;
    @(posedge clk); #1;
    basla8 = 1'b0;
    kontrol("w8_hazir_dusuk", 64'(hazir8), 64'd0);
    @(posedge clk); #1;
    kontrol("w8_tamam", 64'(tamam8), 64'd1);
    kontrol("w8_sonuc", 64'(sonuc8), 64'h0100);
    kontrol("w8_tasma", 64'(tasma8), 64'd1);
    kontrol("w8_gecerli", 64'(gecerli8), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule
`default_nettype wire
